pipe_stage_hs: RTL and testbench

//   Parametrised elastic pipeline register: DEPTH stages of WIDTH-bit data, each with a valid bit.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_slot.sv | 29 ++
 rtl/pipe_stage_hs.sv | 111 +++++++++++
 tb/tb_pipe_stage_hs.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register pipe_stage_hs.
// Defining PIPE_SKID_BUF_EN adds one input skid entry, so capacity becomes DEPTH+1.
package pipe_pkg;
    localparam int WIDTH_DEF = 32;
`ifdef PIPE_SKID_BUF_EN
    localparam int SKID_N = 1;
`else
    localparam int SKID_N = 0;
`endif

    function automatic int cnt_w(input int cap);
        return $clog2(cap + 1);
    endfunction
endpackage

// File: rtl/pipe_slot.sv
// One valid+data register of the elastic pipeline; data only moves with a valid item.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             up_v,
    input  logic [WIDTH-1:0] up_d,
    input  logic             rdy_in,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    always_ff @(posedge clk) begin
        if (clr) begin
            v <= 1'b0;
            d <= '0;
        end else if (rdy_in) begin
            v <= up_v;
            // bubbles advance the valid bit but leave the held data untouched
            if (up_v) begin
                d <= up_d;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Elastic valid/ready pipeline register with bubble collapsing, flush and occupancy count.
// Build option PIPE_SKID_BUF_EN: registered in_ready via one input skid entry.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int DEPTH = 1,
    localparam int CAP   = DEPTH + SKID_N,
    localparam int CW    = cnt_w(CAP)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic             clr;
    logic             acc;
    logic             emit;
    logic             s0_v;
    logic [WIDTH-1:0] s0_d;
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH:0]   rdy;

    assign clr = rst | flush;

    // ready ripples back from the output: an empty stage is always ready
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !v[i] || rdy[i+1];
        end
    end

`ifdef PIPE_SKID_BUF_EN
    logic             sv;
    logic [WIDTH-1:0] sd;

    assign in_ready = !sv && !flush;
    assign acc      = in_valid && in_ready;
    assign s0_v     = sv || acc;
    assign s0_d     = sv ? sd : in_data;

    // while the skid is occupied no input is taken, so draining it keeps order
    always_ff @(posedge clk) begin
        if (clr) begin
            sv <= 1'b0;
            sd <= '0;
        end else if (sv) begin
            if (rdy[0]) begin
                sv <= 1'b0;
            end
        end else if (acc && !rdy[0]) begin
            sv <= 1'b1;
            sd <= in_data;
        end
    end
`else
    assign in_ready = rdy[0] && !flush;
    assign acc      = in_valid && in_ready;
    assign s0_v     = acc;
    assign s0_d     = in_data;
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_first
            pipe_slot #(.WIDTH(WIDTH)) u_slot (
                .clk    (clk),
                .clr    (clr),
                .up_v   (s0_v),
                .up_d   (s0_d),
                .rdy_in (rdy[0]),
                .v      (v[0]),
                .d      (d[0])
            );
        end else begin : g_next
            pipe_slot #(.WIDTH(WIDTH)) u_slot (
                .clk    (clk),
                .clr    (clr),
                .up_v   (v[i-1]),
                .up_d   (d[i-1]),
                .rdy_in (rdy[i]),
                .v      (v[i]),
                .d      (d[i])
            );
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign emit      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (acc && !emit) begin
            count <= count + 1'b1;
        end else if (!acc && emit) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Scoreboard bench for pipe_stage_hs; DEPTH=3 by default, DEPTH=2 when PIPE_SKID_BUF_EN is defined.
module tb_pipe_stage_hs;
    localparam int W = 16;
`ifdef PIPE_SKID_BUF_EN
    localparam int DEPTH = 2;
    localparam int CAP   = DEPTH + 1;
`else
    localparam int DEPTH = 3;
    localparam int CAP   = DEPTH;
`endif
    localparam int CW = $clog2(CAP + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int occ   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int exp_cyc[$];
    int got_cyc[$];

    always #5 clk = ~clk;

    pipe_stage_hs #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    // Called at a negedge: drive, observe the transfers of the coming edge, advance one cycle.
    task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        if (!rst && !flush) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                exp_cyc.push_back(cyc);
                occ++;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                got_cyc.push_back(cyc);
                occ--;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int want);
        for (int k = 0; k < 60 && got_q.size() < want; k++) begin
            step(1'b0, '0, 1'b1);
        end
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        exp_cyc.delete();
        got_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = W'('h5555); out_ready = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        occ = 0;
        clear_q();
    endtask

    task automatic test_streaming();
        step(1'b1, W'('h11), 1'b1);
        step(1'b1, W'('h22), 1'b1);
        step(1'b1, W'('h33), 1'b1);
        drain(3);
        n_cmp++; if (got_q.size() != 3) begin n_bad++; $display("FAIL stream_items: got %0d want 3", got_q.size()); end
        for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
            n_cmp++;
            if (got_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL stream_data[%0d]: got %h want %h", j, got_q[j], exp_q[j]); end
        end
        if (got_q.size() == 3 && exp_q.size() == 3) begin
            n_cmp++;
            if (got_cyc[0] - exp_cyc[0] != DEPTH) begin
                n_bad++; $display("FAIL stream_latency: got %0d want %0d", got_cyc[0] - exp_cyc[0], DEPTH);
            end
            for (int j = 1; j < 3; j++) begin
                n_cmp++;
                if (got_cyc[j] - got_cyc[j-1] != 1) begin
                    n_bad++; $display("FAIL stream_gap[%0d]: got %0d want 1", j, got_cyc[j] - got_cyc[j-1]);
                end
            end
        end
        clear_q();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) step(1'b1, W'('hA0 + i), 1'b0);
        n_cmp++; if (exp_q.size() != CAP) begin n_bad++; $display("FAIL bp_accepted: got %0d want %0d", exp_q.size(), CAP); end
        n_cmp++; if (int'(count) != CAP) begin n_bad++; $display("FAIL bp_count: got %0d want %0d", count, CAP); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        drain(CAP);
        n_cmp++; if (got_q.size() != CAP) begin n_bad++; $display("FAIL bp_drained: got %0d want %0d", got_q.size(), CAP); end
        for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
            n_cmp++;
            if (got_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL bp_data[%0d]: got %h want %h", j, got_q[j], exp_q[j]); end
            if (j > 0) begin
                n_cmp++;
                if (got_cyc[j] - got_cyc[j-1] != 1) begin
                    n_bad++; $display("FAIL bp_gap[%0d]: got %0d want 1", j, got_cyc[j] - got_cyc[j-1]);
                end
            end
        end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_in_ready_back: got %b want 1", in_ready); end
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL bp_count_empty: got %0d want 0", count); end
        clear_q();
    endtask

    task automatic test_bubble();
        step(1'b1, W'('hAAAA), 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, W'('hBBBB), 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        n_cmp++; if (int'(count) != 2) begin n_bad++; $display("FAIL bubble_count: got %0d want 2", count); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bubble_out_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== W'('hAAAA)) begin n_bad++; $display("FAIL bubble_out_data: got %h want aaaa", out_data); end
        drain(2);
        n_cmp++; if (got_q.size() != 2) begin n_bad++; $display("FAIL bubble_items: got %0d want 2", got_q.size()); end
        for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
            n_cmp++;
            if (got_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL bubble_data[%0d]: got %h want %h", j, got_q[j], exp_q[j]); end
        end
        clear_q();
    endtask

    task automatic test_flush();
        for (int i = 0; i < CAP; i++) step(1'b1, W'('hC0 + i), 1'b0);
        n_cmp++; if (int'(count) != CAP) begin n_bad++; $display("FAIL flush_prefill: got %0d want %0d", count, CAP); end
        flush = 1'b1; in_valid = 1'b1; in_data = W'('hEEEE); out_ready = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        cyc++;
        flush = 1'b0; in_valid = 1'b0;
        clear_q();
        occ = 0;
        #1;
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        @(negedge clk);
        cyc++;
        step(1'b1, W'('h5A5A), 1'b1);
        drain(1);
        for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b1);
        n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL flush_after_items: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_cmp++;
            if (got_q[0] !== W'('h5A5A)) begin n_bad++; $display("FAIL flush_after_data: got %h want 5a5a", got_q[0]); end
        end
        clear_q();
    endtask

`ifdef PIPE_SKID_BUF_EN
    task automatic test_skid();
        step(1'b1, W'('h61), 1'b0);
        step(1'b1, W'('h62), 1'b0);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL skid_ready_before: got %b want 1", in_ready); end
        step(1'b1, W'('h63), 1'b0);
        n_cmp++; if (exp_q.size() != 3) begin n_bad++; $display("FAIL skid_accepted: got %0d want 3", exp_q.size()); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL skid_ready_after: got %b want 0", in_ready); end
        n_cmp++; if (int'(count) != 3) begin n_bad++; $display("FAIL skid_count: got %0d want 3", count); end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL skid_ready_comb_up: got %b want 0", in_ready); end
        out_ready = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL skid_ready_comb_down: got %b want 0", in_ready); end
        drain(3);
        n_cmp++; if (got_q.size() != 3) begin n_bad++; $display("FAIL skid_items: got %0d want 3", got_q.size()); end
        for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
            n_cmp++;
            if (got_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL skid_data[%0d]: got %h want %h", j, got_q[j], exp_q[j]); end
        end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL skid_ready_back: got %b want 1", in_ready); end
        clear_q();
    endtask
`else
    task automatic test_back_to_back();
        for (int i = 0; i < CAP; i++) step(1'b1, W'('hD0 + i), 1'b0);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        step(1'b1, W'('hDD), 1'b1);
        n_cmp++; if (int'(count) != CAP) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", count, CAP); end
        drain(CAP + 1);
        n_cmp++; if (got_q.size() != CAP + 1) begin n_bad++; $display("FAIL b2b_items: got %0d want %0d", got_q.size(), CAP + 1); end
        for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
            n_cmp++;
            if (got_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", j, got_q[j], exp_q[j]); end
        end
        clear_q();
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            n_cmp++;
            if (int'(count) != occ) begin n_bad++; $display("FAIL rand_count@%0d: got %0d want %0d", k, count, occ); end
            step(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 3) != 0);
        end
        drain(exp_q.size());
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_items: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
            n_cmp++;
            if (got_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL rand_data[%0d]: got %h want %h", j, got_q[j], exp_q[j]); end
        end
        clear_q();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_flush();
`ifdef PIPE_SKID_BUF_EN
        test_skid();
`else
        test_back_to_back();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
